// File: rtl/f1_pkg.sv
// f1_pkg
// Shared definitions for the F1 race-start sequencer.
//   f1_state_t   : sequencer state encoding (FAULT only with F1_JUMP_START_EN)
//   LIGHTS_ALL   : light bar with every lamp lit
//   LIGHTS_FAULT : alternating pattern shown after a jump start
//   LFSR_TAPS    : tap mask for the 7-bit x^7+x^6+1 LFSR
//   lfsr_step    : one shift of that LFSR
// Optional feature macro: F1_JUMP_START_EN adds the FAULT state.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHT,
    HOLD,
    GO,
    DONE
`ifdef F1_JUMP_START_EN
    , FAULT
`endif
  } f1_state_t;

  localparam logic [7:0] LIGHTS_ALL   = 8'hFF;
  localparam logic [7:0] LIGHTS_FAULT = 8'hAA;

  // Bits 6 and 5 correspond to the x^7 and x^6 terms.
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

  // Fibonacci shift: XOR of the tapped bits enters at the bottom.
  function automatic logic [6:0] lfsr_step(input logic [6:0] q);
    return {q[5:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr7.sv
// lfsr7
// Free-running 7-bit maximal-length LFSR (x^7+x^6+1). It steps on every
// clock outside reset and cycles through all 127 non-zero values.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset, reloads SEED
//   value : current LFSR contents (never zero for a non-zero SEED)
module lfsr7
  import f1_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl
// Race-start sequencer: lights the bar one lamp per tick, holds all lamps
// for a pseudo-random number of ticks, extinguishes them and then measures
// the driver's reaction time in clock cycles.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   trigger   : start request, acted on only in IDLE (and FAULT)
//   tick      : one-cycle enable strobe from the clktick divider
//   react     : driver button
//   data_out  : 8-bit light bar
//   busy      : high whenever the sequencer is not idle
//   rt_valid  : one-cycle pulse when rt_cycles is updated
//   rt_cycles : last reaction time, saturating at all-ones
//   fault     : jump-start indicator
// Optional feature macro: F1_JUMP_START_EN enables jump-start detection
// (FAULT state); without it, fault is tied low.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int         CNT_W = 16,
  parameter logic [6:0] SEED  = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             tick,
  input  logic             react,
  output logic [7:0]       data_out,
  output logic             busy,
  output logic             rt_valid,
  output logic [CNT_W-1:0] rt_cycles,
  output logic             fault
);

  f1_state_t        state, state_next;
  logic [7:0]       data_next;
  logic [6:0]       lfsr_q;
  logic [6:0]       hold_cnt, hold_next;
  logic [CNT_W-1:0] rt_cnt, rt_cnt_next, rt_cycles_next;

  lfsr7 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_q)
  );

  always_comb begin
    state_next     = state;
    data_next      = data_out;
    hold_next      = hold_cnt;
    rt_cnt_next    = rt_cnt;
    rt_cycles_next = rt_cycles;

    case (state)
      IDLE: begin
        data_next = 8'h00;
        if (trigger) begin
          state_next = LIGHT;
        end
      end

      LIGHT: begin
`ifdef F1_JUMP_START_EN
        // A press before lights-out wins over a tick in the same cycle.
        if (react) begin
          state_next = FAULT;
          data_next  = LIGHTS_FAULT;
        end else
`endif
        if (tick) begin
          data_next = {data_out[6:0], 1'b1};
          // This tick lights the last lamp; capture the hold length now.
          if (data_out == 8'h7F) begin
            state_next = HOLD;
            hold_next  = lfsr_q;
          end
        end
      end

      HOLD: begin
        data_next = LIGHTS_ALL;
`ifdef F1_JUMP_START_EN
        if (react) begin
          state_next = FAULT;
          data_next  = LIGHTS_FAULT;
        end else
`endif
        if (tick) begin
          if (hold_cnt == 7'd1) begin
            state_next  = GO;
            data_next   = 8'h00;
            rt_cnt_next = '0;
          end else begin
            hold_next = hold_cnt - 7'd1;
          end
        end
      end

      GO: begin
        data_next = 8'h00;
        if (!(&rt_cnt)) begin
          rt_cnt_next = rt_cnt + CNT_W'(1);
        end
        if (react) begin
          rt_cycles_next = rt_cnt;
          state_next     = DONE;
        end
      end

      DONE: begin
        data_next  = 8'h00;
        state_next = IDLE;
      end

`ifdef F1_JUMP_START_EN
      FAULT: begin
        data_next = LIGHTS_FAULT;
        // The clearing trigger is consumed here and does not start a run.
        if (trigger) begin
          state_next = IDLE;
          data_next  = 8'h00;
        end
      end
`endif

      default: begin
        state_next = IDLE;
        data_next  = 8'h00;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_out  <= 8'h00;
      busy      <= 1'b0;
      rt_valid  <= 1'b0;
      rt_cycles <= '0;
      hold_cnt  <= 7'd0;
      rt_cnt    <= '0;
    end else begin
      state     <= state_next;
      data_out  <= data_next;
      busy      <= (state_next != IDLE);
      rt_valid  <= (state_next == DONE);
      rt_cycles <= rt_cycles_next;
      hold_cnt  <= hold_next;
      rt_cnt    <= rt_cnt_next;
    end
  end

`ifdef F1_JUMP_START_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= (state_next == FAULT);
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb_f1_start_ctrl
// Self-checking bench for f1_start_ctrl (CNT_W=6 so saturation is reachable).
// Light-bar changes and reaction-time results are checked by a monitor
// against queues filled by the stimulus; hold lengths come from a table of
// the x^7+x^6+1 sequence indexed by clock edges since reset.
// Honours F1_JUMP_START_EN for the jump-start expectations.
module tb_f1_start_ctrl;

  localparam int         CNT_W = 6;
  localparam logic [6:0] SEED  = 7'h01;
  localparam int         SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             trigger;
  logic             tick;
  logic             react;
  logic [7:0]       data_out;
  logic             busy;
  logic             rt_valid;
  logic [CNT_W-1:0] rt_cycles;
  logic             fault;

  int checks = 0;
  int errors = 0;

  logic [7:0]       exp_lights[$];
  int               exp_rt[$];
  logic [6:0]       seq[127];
  int               nr_edges;
  logic             mon_en;
  logic [7:0]       last_lights;
  logic [7:0]       mon_l;
  int               mon_r;

  f1_start_ctrl #(.CNT_W(CNT_W), .SEED(SEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .tick      (tick),
    .react     (react),
    .data_out  (data_out),
    .busy      (busy),
    .rt_valid  (rt_valid),
    .rt_cycles (rt_cycles),
    .fault     (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Non-reset edges since the last reset; the LFSR value sampled at the next
  // edge is seq[nr_edges % 127].
  always @(posedge clk) begin
    if (rst) nr_edges <= 0;
    else     nr_edges <= nr_edges + 1;
  end

  // Scoreboard monitor: every light-bar change and every result pulse must
  // match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_out !== last_lights) begin
        checks++;
        if (exp_lights.size() == 0) begin
          errors++;
          $display("[TB] FAIL lights_change: got %h, expected no change from %h", data_out, last_lights);
        end else begin
          mon_l = exp_lights.pop_front();
          if (data_out !== mon_l) begin
            errors++;
            $display("[TB] FAIL lights_change: got %h, expected %h", data_out, mon_l);
          end
        end
        last_lights = data_out;
      end
      if (rt_valid === 1'b1) begin
        checks++;
        if (exp_rt.size() == 0) begin
          errors++;
          $display("[TB] FAIL rt_result: got unexpected pulse with %0d", rt_cycles);
        end else begin
          mon_r = exp_rt.pop_front();
          if (int'(rt_cycles) != mon_r) begin
            errors++;
            $display("[TB] FAIL rt_result: got %0d, expected %0d", rt_cycles, mon_r);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic t, input logic tk, input logic r);
    trigger = t;
    tick    = tk;
    react   = r;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    tick    = 1'b0;
    react   = 1'b0;
  endtask

  // Idle cycles without ticks while the sequence is running; stray triggers
  // must be ignored.
  task automatic gap();
    int g = $urandom_range(0, 2);
    repeat (g) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic runLights(output int hold_n);
    logic [7:0] v;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("busy_after_trigger", 32'(busy), 32'd1);
    checkOutput("lights_after_trigger", 32'(data_out), 32'h00);
    hold_n = 0;
    for (int i = 0; i < 8; i++) begin
      gap();
      if (i == 7) hold_n = int'(seq[nr_edges % 127]);
      v = 8'((9'h1 << (i + 1)) - 9'h1);
      exp_lights.push_back(v);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("lights_step", 32'(data_out), 32'(v));
    end
  endtask

  task automatic runHold(input int n);
    for (int i = 0; i < n - 1; i++) begin
      gap();
      applyStimulus(1'b0, 1'b1, 1'b0);
    end
    checkOutput("hold_not_early", 32'(data_out), 32'hFF);
    gap();
    exp_lights.push_back(8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("go_lights_out", 32'(data_out), 32'h00);
    checkOutput("go_busy", 32'(busy), 32'd1);
  endtask

  task automatic runGo(input int d);
    int e = (d > SAT) ? SAT : d;
    for (int i = 0; i < d; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    exp_rt.push_back(e);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_rt_cycles", 32'(rt_cycles), 32'(e));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rt_valid", 32'(rt_valid), 32'd0);
    checkOutput("rt_cycles_held", 32'(rt_cycles), 32'(e));
  endtask

  task automatic runFull(input int d);
    int n;
    runLights(n);
    runHold(n);
    runGo(d);
  endtask

  initial begin
    logic [6:0] v;
    int n;
    v = SEED;
    for (int i = 0; i < 127; i++) begin
      seq[i] = v;
      v = {v[5:0], v[6] ^ v[5]};
    end
    mon_en = 1'b0; last_lights = 8'h00;
    trigger = 1'b0; tick = 1'b0; react = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data_out", 32'(data_out), 32'h00);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rt_valid", 32'(rt_valid), 32'd0);
    checkOutput("reset_rt_cycles", 32'(rt_cycles), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    $display("[TB] idle with ticks");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("idle_quiet", {22'd0, fault, rt_valid, busy, data_out}, 32'd0);
    end

    $display("[TB] full run, react at 37");
    runFull(37);

    $display("[TB] trigger 5 cycles after reset");
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    runFull($urandom_range(0, 50));

    $display("[TB] saturating result");
    runFull(80);

    $display("[TB] react during hold");
    runLights(n);
`ifdef F1_JUMP_START_EN
    exp_lights.push_back(8'hAA);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("fault_lights", 32'(data_out), 32'hAA);
    checkOutput("fault_flag", 32'(fault), 32'd1);
    checkOutput("fault_busy", 32'(busy), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    checkOutput("fault_sticky", 32'(data_out), 32'hAA);
    exp_lights.push_back(8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fault_clear_busy", 32'(busy), 32'd0);
    checkOutput("fault_clear_flag", 32'(fault), 32'd0);
    checkOutput("fault_clear_lights", 32'(data_out), 32'h00);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("fault_no_restart", 32'(busy), 32'd0);
`else
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("react_ignored_lights", 32'(data_out), 32'hFF);
    checkOutput("react_ignored_fault", 32'(fault), 32'd0);
    checkOutput("react_ignored_busy", 32'(busy), 32'd1);
    runHold(n);
    runGo(5);
`endif

    $display("[TB] reset during hold");
    runLights(n);
    exp_lights.push_back(8'h00);
    doReset();
    checkOutput("rst_mid_lights", 32'(data_out), 32'h00);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_rt_cycles", 32'(rt_cycles), 32'd0);
    checkOutput("rst_mid_fault", 32'(fault), 32'd0);
    runFull($urandom_range(0, 70));

    $display("[TB] random runs");
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(0, 10)) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      runFull($urandom_range(0, 70));
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lights_queue_drained", 32'(exp_lights.size()), 32'd0);
    checkOutput("rt_queue_drained", 32'(exp_rt.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f1_start_ctrl.md
# f1_start_ctrl

Race-start sequencer for the F1 lights datapath. It consumes the `tick` strobe from the existing `clktick` divider and drives the 8-bit light bar. On a start request it lights the bar one lamp per tick, holds all lamps for a pseudo-random number of ticks, then extinguishes them. It then measures the driver's reaction time in clock cycles and reports the result with a one-cycle valid strobe.

## Interface
Parameters:
- `CNT_W`, default 16: width of the reaction-time counter and result.
- `SEED`, default 7'h01: LFSR reset value. Must be non-zero.

Ports:
- `clk`, input, 1: system clock. This is the only clock.
- `rst`, input, 1: synchronous, active-high reset.
- `trigger`, input, 1: start request. Level-sampled, acted on only in IDLE.
- `tick`, input, 1: one-cycle enable strobe from `clktick`.
- `react`, input, 1: driver button. Level-sampled.
- `data_out`, output, 8: light bar.
- `busy`, output, 1: high whenever the state is not IDLE.
- `rt_valid`, output, 1: one-cycle pulse when a result is ready.
- `rt_cycles`, output, CNT_W: last reaction time. Held until the next result.
- `fault`, output, 1: jump-start indicator.

## Operation
- States: IDLE, LIGHT, HOLD, GO, DONE, and FAULT (FAULT exists only with the macro).
- LFSR:
  - 7-bit maximal-length, polynomial x^7+x^6+1.
  - Advances every `clk` from reset, so the hold length depends on when `trigger` arrives.
  - Never reaches 0.
- IDLE:
  - `data_out`=8'h00.
  - `trigger`=1 moves to LIGHT.
- LIGHT:
  - On each `tick`, `data_out` <= {`data_out`[6:0],1'b1}.
  - The tick that produces 8'hFF moves to HOLD and loads `hold_cnt` with the current LFSR value (1..127).
- HOLD:
  - `data_out`=8'hFF.
  - On each `tick`: if `hold_cnt`==1, move to GO; otherwise decrement `hold_cnt`.
  - HOLD therefore lasts exactly `hold_cnt` ticks.
- GO:
  - `data_out`=8'h00.
  - `rt_cnt` is 0 in the first GO cycle and increments every cycle, saturating at all-ones.
  - `react`=1 in a GO cycle latches `rt_cycles`<=`rt_cnt` and moves to DONE.
- DONE:
  - `rt_valid`=1 for exactly one cycle.
  - Returns to IDLE.
- Boundary rules:
  - `trigger` outside IDLE is ignored.
  - `tick` has no effect in GO, DONE or IDLE.
  - `react` has no effect in IDLE or DONE.
  - The result saturates: if `react` arrives after the counter reaches all-ones, `rt_cycles`=all-ones.
  - `rst` mid-sequence returns to IDLE and reseeds the LFSR. `rt_cycles` is cleared.
- Reset values:
  - `data_out`=0, `busy`=0, `rt_valid`=0, `rt_cycles`=0, `fault`=0.
  - State IDLE, LFSR=`SEED`.

## Timing
- All outputs are registered.
- `trigger` sampled at edge k: `busy`=1 from k+1 and `data_out`=8'h00 from k+1.
- A `tick` sampled at edge j updates `data_out` at j+1.
- Eight ticks take the bar from 8'h00 to 8'hFF.
- The final HOLD tick at edge j gives `data_out`=8'h00 at j+1, and that is GO cycle 0.
- `react` sampled in GO cycle c gives `rt_valid`=1 and `rt_cycles`=c in the next cycle. `busy` drops one cycle after that.
- Minimum start-to-lights-out time is 9 ticks. Maximum is 135 ticks.

## Configuration
- `F1_JUMP_START_EN` defined:
  - `react`=1 in LIGHT or HOLD moves to FAULT.
  - `react` has priority over a simultaneous `tick`.
  - In FAULT: `data_out`=8'hAA, `fault`=1, `busy`=1, no result is produced.
  - `trigger`=1 in FAULT returns to IDLE and clears `fault`. This trigger is consumed and does not start a sequence.
- `F1_JUMP_START_EN` undefined:
  - `react` is ignored outside GO.
  - The FAULT state is not compiled.
  - `fault` is tied to 0.

## Structure
- Package `f1_pkg` holds:
  - the state enum `f1_state_t`,
  - `LIGHTS_ALL`=8'hFF,
  - `LIGHTS_FAULT`=8'hAA,
  - `LFSR_TAPS`.
- Sub-module `lfsr7` contains the free-running LFSR with `SEED`, using `clk` and `rst`.
- The FSM and counters live in `f1_start_ctrl`.

## Test plan
- Reset, then idle for 20 cycles with ticks present: all outputs stay 0 and `busy`=0.
- `trigger`, then 8 ticks: `data_out` steps 01,03,07,0F,1F,3F,7F,FF, each one cycle after its tick.
- With `SEED`=7'h01, `trigger` asserted 5 cycles after reset release: the hold lasts the LFSR value for that cycle (compute it in the model), then `data_out`=00.
- `react` raised 37 cycles after GO cycle 0: `rt_valid` pulses once, `rt_cycles`=37, and the state returns to IDLE.
- With the macro defined, `react` during HOLD: `data_out`=AA and `fault`=1. A following `trigger` returns to IDLE without starting. Without the macro, the same stimulus is ignored.
- `rst` during HOLD: the next cycle shows IDLE outputs, and a new `trigger` restarts from 8'h00.
